// File: rtl/alu_wide_if.sv
// Bus for the wide multi-cycle ALU.
// Handshake: the requester raises start together with op/ai/bi/ci/dec. The
// request is taken only in a cycle where busy=0 and the ALU is idle (never in
// the done cycle). done pulses for exactly one cycle, and out/status are valid
// from that cycle. Nothing is queued: a start raised at any other time is
// dropped.
interface alu_wide_if #(parameter int W = 16);
    logic         start;
    logic [5:0]   op;
    logic [W-1:0] ai;
    logic [W-1:0] bi;
    logic         ci;
    logic         dec;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic [7:0]   status;

    modport master (output start, op, ai, bi, ci, dec,
                    input  busy, done, out, status);
    modport slave  (input  start, op, ai, bi, ci, dec,
                    output busy, done, out, status);
endinterface

// File: rtl/alu_wide.sv
// Width-parametrised 6502-style ALU. It works on one 8-bit slice per clock
// and passes the carry or shifted-out bit from slice to slice. add/subtract
// also support BCD mode.
// op[5] unary (a=bi), op[4] use ci, op[3] sum, op[2] force carry,
// op[1] inc/dec (b=0), op[0] invert b.
// When op[3]=0, op[2:0] picks a logic or shift operation (see ALU_* below).
module alu_wide #(
    parameter int W = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_wide_if.slave  bus,
    output logic [1:0] dbg_state
);
    localparam int NS = W / 8;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [2:0] ALU_ORA = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_EOR = 3'b010;
    localparam logic [2:0] ALU_BIT = 3'b011;
    localparam logic [2:0] ALU_ASL = 3'b100;
    localparam logic [2:0] ALU_LSR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    op_q, op_d;
    logic [W-1:0]  ai_q, ai_d;
    logic [W-1:0]  bi_q, bi_d;
    logic [W-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic          dec_q, dec_d;
    logic [W-1:0]  out_q, out_d;
    logic [7:0]    status_q, status_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // BCD digit step: {carry_out, digit}. On add the digit is adjusted by +6
    // when it exceeds 9 or carries out. On subtract it is adjusted by -6 when
    // it borrows.
    function automatic logic [4:0] dec_nib(input logic [3:0] x, input logic [3:0] y,
                                           input logic c, input logic sub);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0, c};
        if (!sub) begin
            if (s > 5'd9 || s[4]) s = {1'b1, s[3:0] + 4'd6};
        end else begin
            if (!s[4]) s = {1'b0, s[3:0] - 4'd6};
        end
        return s;
    endfunction

    logic         is_sum, is_lsr, is_bit, use_dec, last, init_carry, cin;
    logic [W-1:0] a_w, res_new;
    int           sidx;
    logic [7:0]   a_s, ai_s, bi_s, b_s, r_s;
    logic [8:0]   bin;
    logic [4:0]   lo, hi;
    logic         cout, f_n, f_v, f_z;

    // Slice datapath: select this cycle's slice, compute it, and merge it into the result.
    always_comb begin
        is_sum  = op_q[3];
        is_lsr  = !op_q[3] && (op_q[2:0] == ALU_LSR);
        is_bit  = !op_q[3] && (op_q[2:0] == ALU_BIT);
        use_dec = dec_q && !op_q[1];
        a_w     = op_q[5] ? bi_q : ai_q;
        // LSR has to run MSB slice first so the shifted-in bit moves downwards.
        sidx    = is_lsr ? (NS - 1 - int'(cnt_q)) : int'(cnt_q);
        a_s     = a_w[sidx*8 +: 8];
        ai_s    = ai_q[sidx*8 +: 8];
        bi_s    = bi_q[sidx*8 +: 8];
        b_s     = op_q[1] ? 8'h00 : bi_s;
        if (op_q[0]) b_s = ~b_s;
        bin     = {1'b0, a_s} + {1'b0, b_s} + {8'b0, carry_q};
        lo      = dec_nib(a_s[3:0], b_s[3:0], carry_q, op_q[0]);
        hi      = dec_nib(a_s[7:4], b_s[7:4], lo[4], op_q[0]);
        r_s     = ai_s;
        cout    = 1'b0;
        if (is_sum) begin
            if (use_dec) begin
                r_s  = {hi[3:0], lo[3:0]};
                cout = hi[4];
            end else begin
                r_s  = bin[7:0];
                cout = bin[8];
            end
        end else begin
            case (op_q[2:0])
                ALU_ORA: r_s = ai_s | bi_s;
                ALU_AND: r_s = ai_s & bi_s;
                ALU_EOR: r_s = ai_s ^ bi_s;
                ALU_BIT: r_s = ai_s & bi_s;
                ALU_ASL: begin
                    r_s  = {a_s[6:0], carry_q};
                    cout = a_s[7];
                end
                ALU_LSR: begin
                    r_s  = {carry_q, a_s[7:1]};
                    cout = a_s[0];
                end
                default: r_s = ai_s;
            endcase
        end
        res_new = res_q;
        res_new[sidx*8 +: 8] = r_s;
        last = (cnt_q == CW'(NS - 1));
        // V is taken from the binary sum even in BCD mode. The final slice of a sum op is the top slice.
        f_n  = is_bit ? bi_q[W-1] : res_new[W-1];
        f_v  = is_sum ? ((a_s[7] ^ bin[7]) & (b_s[7] ^ bin[7])) : bi_q[W-2];
        f_z  = (res_new == '0);
    end

    // Carry into slice 0, taken from the request as it is accepted.
    always_comb begin
        cin = bus.op[4] & bus.ci;
        if (bus.op[3]) begin
            if (bus.op[1])      init_carry = !bus.op[0];
            else if (bus.op[2]) init_carry = 1'b1;
            else                init_carry = cin;
        end else begin
            init_carry = cin;
        end
    end

    // Control FSM next state: IDLE accepts a request, RUN does NS slices, DONE pulses done.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        ai_d     = ai_q;
        bi_d     = bi_q;
        res_d    = res_q;
        carry_d  = carry_q;
        dec_d    = dec_q;
        out_d    = out_q;
        status_d = status_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    ai_d    = bus.ai;
                    bi_d    = bus.bi;
                    dec_d   = bus.dec;
                    carry_d = init_carry;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = res_new;
                carry_d = cout;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    out_d    = res_new;
                    status_d = {f_n, f_v, 4'b0000, f_z, cout};
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers. Reset drops any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            ai_q     <= '0;
            bi_q     <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            dec_q    <= 1'b0;
            out_q    <= '0;
            status_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            ai_q     <= ai_d;
            bi_q     <= bi_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            dec_q    <= dec_d;
            out_q    <= out_d;
            status_q <= status_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.out    = out_q;
    assign bus.status = status_q;
    assign dbg_state  = state_q;
endmodule

// File: doc/alu_wide.md
Name: alu_wide

Overview:
- Multi-cycle, width-parametrised successor to the 8-bit 6502 ALU.
- Processes W-bit operands one 8-bit slice per clock, with carry/shift chaining between slices.
- Adds 6502 decimal (BCD) mode for add/subtract.
- Serves wide-arithmetic co-processing (16/24/32-bit pointer and counter math) next to the core datapath, using a start/busy/done handshake.

Parameters:
- W, 16, operand/result width in bits; must be a multiple of 8, minimum 8; NS = W/8 slices.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when busy=0
- op  in  6  operation code, same field semantics and ALU_* logic codes as the core ALU
- ai  in  W  operand A
- bi  in  W  operand B (also the unary source when op[5]=1)
- ci  in  1  carry in; used only when op[4]=1
- dec  in  1  decimal mode; applies to add/subtract only
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; out/status valid from this cycle
- out  out  W  result; held until the next accepted start
- status  out  8  bit7 N, bit6 V, bit1 Z, bit0 C; all other bits 0

Behaviour:
- Reset: busy=0, done=0, out=0, status=0, FSM=IDLE. Reset mid-operation aborts immediately and discards the partial result.

FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE: on start, latch op, ai, bi, ci, dec; set slice counter to 0; go to RUN. busy=1 from the next cycle.
- RUN: process one slice per cycle for NS cycles.
- DONE: done=1 for one cycle; out/status updated and busy=0 in this cycle. Return to IDLE.
- Latency: start in cycle T0 -> done in T(NS+1). For W=16, done is in T3.
- start while busy=1, or in the DONE cycle, is ignored. No queueing.

Operand select and carry:
- a = op[5] ? bi : ai; b = bi.
- cin = op[4] & ci.

Sum ops (op[3]=1), processed LSB slice first:
- Slice 0 carry-in:
  - op[1]=1 (inc/dec): b=0, carry = !op[0].
  - else op[2]=1: carry = 1.
  - else: carry = cin.
- Slice k>0 carry-in = carry-out of slice k-1.
- op[0]=1: invert b in every slice.
- V = (a[W-1]^r[W-1]) & (b'[W-1]^r[W-1]) on the binary top-slice sum, where b' is b after inversion.
- C = final carry-out.

Decimal mode (dec=1, op[3]=1, op[1]=0):
- Applied per nibble, with the nibble carry chained across nibbles and slices.
- Add (op[0]=0): if nibble sum > 9 or nibble carry-out, add 6 and force nibble carry-out = 1.
- Subtract (op[0]=1): if nibble carry-out = 0, subtract 6 (mod 16).
- N, Z, C come from the corrected result. V comes from the uncorrected binary top slice.
- Inputs containing invalid BCD digits give a defined-but-unspecified result. This is not checked.

Shifts:
- ASL: LSB slice first; bit 0 of slice 0 = cin; C = a[W-1].
- LSR: MSB slice first; bit W-1 = cin; C = a[0].
- Intermediate slices chain the shifted-out bit.

Logic ops:
- AND, ORA, XOR, BIT: slice-wise on ai/bi; C=0.
- Undefined codes pass ai through.
- V=bi[W-2] for all non-sum ops (meaningful only for BIT).
- BIT: result = ai & bi; N = bi[W-1].

Flags (all ops):
- N = out[W-1] except for BIT.
- Z = (full W-bit result == 0), never per slice.

Wrap-around: all arithmetic is mod 2^W; the carry/borrow shows only in C.

Test Plan:
- W=16 add (op[3], op[4]=1): ai=0x12FF, bi=0x0001, ci=0 -> start at T0, done at T3; out=0x1300, N=0, V=0, Z=0, C=0. busy=1 in T1-T2, busy=0 in T3.
- Unary dec (op[5], op[3], op[1], op[0]): bi=0x0000 -> out=0xFFFF, N=1, Z=0, C=0. Unary inc on bi=0xFFFF -> out=0x0000, Z=1, C=1.
- Decimal add, ci=0:
  - 0x0999+0x0001 -> 0x1000, C=0.
  - 0x9999+0x0001 -> 0x0000, Z=1, C=1.
- Decimal subtract, ci=1: 0x1000-0x0001 -> 0x0999, C=1. Binary subtract, ci=1: 0x8000-0x0001 -> 0x7FFF, V=1, C=1.
- Shifts:
  - LSR with op[4]=1, ci=1, ai=0x8001 -> 0xC000, C=1.
  - ASL with ci=0, ai=0x8001 -> 0x0002, C=1.
  - BIT: ai=0x00FF, bi=0xC000 -> Z=1, N=1, V=1.
- Control:
  - start re-asserted in T1 with new operands is ignored; the first result is unchanged.
  - rst in T2 -> busy=0, done never pulses, out=0, status=0.
  - A new start at T4 completes normally.
